// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory responder: byte width, opcodes,
// FSM state encoding and command validation.
// Optional feature macro: SPI_MEM_STATUS_EN (adds READ_STATUS opcode).
package spi_mem_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] SINGLE_WRITE = 3'b001;
  localparam logic [2:0] SINGLE_READ  = 3'b010;
  localparam logic [2:0] BURST_WRITE  = 3'b011;
  localparam logic [2:0] BURST_READ   = 3'b100;
  localparam logic [2:0] READ_STATUS  = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    ERR
  } state_t;

  // Command byte is valid when the upper five bits are zero and the opcode is known
  function automatic logic cmd_valid(input logic [BYTE_W-1:0] cmd);
    logic op_ok;
    case (cmd[2:0])
      SINGLE_WRITE, SINGLE_READ, BURST_WRITE, BURST_READ: op_ok = 1'b1;
`ifdef SPI_MEM_STATUS_EN
      READ_STATUS: op_ok = 1'b1;
`endif
      default: op_ok = 1'b0;
    endcase
    return op_ok && (cmd[BYTE_W-1:3] == '0);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall pulse generation for an
// asynchronous SPI pin sampled in the system clock domain.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q_d;

  // Synchronize the pin and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      q_d  <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder in front of a register-file memory.
// All SPI pins are oversampled in the clk domain; nothing runs on sclk.
// Frame: command byte, address byte, then data bytes.
// Optional macro SPI_MEM_STATUS_EN enables READ_STATUS (opcode 101) which
// returns a saturating count of invalid commands and clears it on completion.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              cmd_err,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (DATA_W != BYTE_W) begin : g_bad_data_w
    $error("spi_mem_responder: DATA_W must equal BYTE_W (8)");
  end

  logic unused_cs_lvl, cs_rise, cs_fall;
  logic unused_sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(cs),
    .q(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .d(mosi),
    .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  state_t             state;
  logic [2:0]         bitcnt;
  logic [2:0]         ocnt;
  logic [BYTE_W-2:0]  shreg;
  logic [BYTE_W-2:0]  txreg;
  logic [2:0]         op;
  logic [ADDR_W-1:0]  addr;
  logic               wdone;
  logic               rd_active;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [BYTE_W-1:0]  rx_byte;
  logic [BYTE_W-1:0]  tx_byte;
`ifdef SPI_MEM_STATUS_EN
  logic [3:0]         err_cnt;
`endif

  assign rx_byte = {shreg, mosi_s};

  // Select the byte to start shifting out: memory word or status byte
  always_comb begin
    tx_byte = mem[addr];
`ifdef SPI_MEM_STATUS_EN
    if (op == READ_STATUS) tx_byte = {{(BYTE_W-4){1'b0}}, err_cnt};
`endif
  end

  // Frame FSM, memory and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      ocnt      <= '0;
      shreg     <= '0;
      txreg     <= '0;
      op        <= '0;
      addr      <= '0;
      wdone     <= 1'b0;
      rd_active <= 1'b0;
      miso      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
`ifdef SPI_MEM_STATUS_EN
      err_cnt   <= '0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      cmd_err   <= 1'b0;

      if (sclk_rise && (state == CMD || state == ADDR || state == WDATA)) begin
        shreg  <= rx_byte[BYTE_W-2:0];
        bitcnt <= bitcnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state  <= CMD;
            busy   <= 1'b1;
            bitcnt <= '0;
            ocnt   <= '0;
          end
        end
        CMD: begin
          if (sclk_rise && bitcnt == 3'd7) begin
            op <= rx_byte[2:0];
            if (cmd_valid(rx_byte)) begin
`ifdef SPI_MEM_STATUS_EN
              if (rx_byte[2:0] == READ_STATUS) begin
                state     <= RDATA;
                rd_active <= 1'b1;
                ocnt      <= '0;
              end else begin
                state <= ADDR;
              end
`else
              state <= ADDR;
`endif
            end else begin
              state   <= ERR;
              cmd_err <= 1'b1;
`ifdef SPI_MEM_STATUS_EN
              if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
`endif
            end
          end
        end
        ADDR: begin
          if (sclk_rise && bitcnt == 3'd7) begin
            addr <= ADDR_W'(rx_byte);
            if (op == SINGLE_WRITE || op == BURST_WRITE) begin
              state <= WDATA;
              wdone <= 1'b0;
            end else begin
              state     <= RDATA;
              rd_active <= 1'b1;
              ocnt      <= '0;
            end
          end
        end
        WDATA: begin
          if (sclk_rise && bitcnt == 3'd7 && !wdone) begin
            mem[addr] <= rx_byte;
            wr_strobe <= 1'b1;
            wr_addr   <= addr;
            if (op == BURST_WRITE) addr  <= addr + ADDR_W'(1);
            else                   wdone <= 1'b1;
          end
        end
        RDATA: begin
          // Byte fetch happens on the first falling edge of each byte so a
          // burst picks up the already-incremented address.
          if (sclk_fall) begin
            ocnt <= ocnt + 3'd1;
            if (ocnt == 3'd0) begin
              miso  <= rd_active & tx_byte[BYTE_W-1];
              txreg <= rd_active ? tx_byte[BYTE_W-2:0] : '0;
            end else begin
              miso  <= rd_active & txreg[BYTE_W-2];
              txreg <= {txreg[BYTE_W-3:0], 1'b0};
            end
            if (ocnt == 3'd7 && rd_active) begin
              if (op == BURST_READ) begin
                addr <= addr + ADDR_W'(1);
              end else begin
                rd_active <= 1'b0;
`ifdef SPI_MEM_STATUS_EN
                if (op == READ_STATUS) err_cnt <= '0;
`endif
              end
            end
          end
        end
        ERR: miso <= 1'b0;
        default: state <= IDLE;
      endcase

      // cs release overrides the state update but not a commit in the same clk
      if (cs_rise) begin
        state     <= IDLE;
        busy      <= 1'b0;
        miso      <= 1'b0;
        bitcnt    <= '0;
        ocnt      <= '0;
        rd_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed and randomized bench for spi_mem_responder acting as SPI master.
module tb_spi_mem_responder;

  localparam int unsigned HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic       cmd_err;
  logic       busy;

  spi_mem_responder #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .mosi(mosi),
    .miso(miso), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wr_cnt = 0;
  int unsigned ce_cnt = 0;
  logic [7:0]  wr_log[$];
  logic [7:0]  fb[8];
  logic [7:0]  fr[8];
  logic [7:0]  mem_m[256];

  always @(negedge clk) begin
    if (wr_strobe) begin
      wr_cnt++;
      wr_log.push_back(wr_addr);
    end
    if (cmd_err) ce_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_frame(input int unsigned nbits, input bit raise_cs);
    for (int unsigned k = 0; k < 8; k++) fr[k] = '0;
    cs = 1'b0;
    repeat (10) @(negedge clk);
    for (int unsigned b = 0; b < nbits; b++) begin
      mosi = fb[b/8][7-(b%8)];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      fr[b/8][7-(b%8)] = miso;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    if (raise_cs) begin
      repeat (HALF) @(negedge clk);
      cs   = 1'b1;
      mosi = 1'b0;
      repeat (12) @(negedge clk);
    end
  endtask

  function automatic bit ref_valid(input logic [7:0] c);
`ifdef SPI_MEM_STATUS_EN
    return c inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`else
    return c inside {8'h01, 8'h02, 8'h03, 8'h04};
`endif
  endfunction

  initial begin
    int unsigned w0, e0, nbits, nbytes, full, exp_wr, exp_err;
    logic [7:0] cmd, a, idx, expb;
    logic [7:0] exp_addr[$];
    int unsigned scnt;

    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_busy", busy, 0);

    // busy tracks synchronized cs
    cs = 1'b0; repeat (10) @(negedge clk);
    check("busy_high", busy, 1);
    cs = 1'b1; repeat (10) @(negedge clk);
    check("busy_low", busy, 0);

    // single write then single read
    w0 = wr_cnt;
    fb[0] = 8'h01; fb[1] = 8'h10; fb[2] = 8'hA5;
    spi_frame(24, 1);
    check("sw_count", wr_cnt - w0, 1);
    check("sw_addr", wr_log[w0], 8'h10);
    fb[0] = 8'h02; fb[1] = 8'h10; fb[2] = 8'h00; fb[3] = 8'h00;
    spi_frame(32, 1);
    check("sr_addr_byte_miso", fr[1], 0);
    check("sr_data", fr[2], 8'hA5);
    check("sr_after_byte", fr[3], 0);

    // burst write with wrap, then burst read back
    w0 = wr_cnt;
    fb[0] = 8'h03; fb[1] = 8'hFE; fb[2] = 8'h11; fb[3] = 8'h22; fb[4] = 8'h33;
    spi_frame(40, 1);
    check("bw_count", wr_cnt - w0, 3);
    check("bw_addr0", wr_log[w0], 8'hFE);
    check("bw_addr1", wr_log[w0+1], 8'hFF);
    check("bw_addr2", wr_log[w0+2], 8'h00);
    fb[0] = 8'h04; fb[1] = 8'hFE; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h00;
    spi_frame(40, 1);
    check("br_data0", fr[2], 8'h11);
    check("br_data1", fr[3], 8'h22);
    check("br_data2", fr[4], 8'h33);

    // invalid commands: error pulse, no writes, silent miso
    w0 = wr_cnt; e0 = ce_cnt;
    fb[0] = 8'h07; fb[1] = 8'h10; fb[2] = 8'h5A;
    spi_frame(24, 1);
    check("inv07_err", ce_cnt - e0, 1);
    check("inv07_miso", {fr[0], fr[1], fr[2]}, 0);
    fb[0] = 8'h81;
    spi_frame(24, 1);
    check("inv81_err", ce_cnt - e0, 2);
    check("inv_no_write", wr_cnt - w0, 0);
    fb[0] = 8'h02; fb[1] = 8'h10; fb[2] = 8'h00;
    spi_frame(24, 1);
    check("inv_mem_kept", fr[2], 8'hA5);

    // cs abort mid data byte
    fb[0] = 8'h01; fb[1] = 8'h20; fb[2] = 8'h3C;
    spi_frame(24, 1);
    w0 = wr_cnt;
    fb[2] = 8'hC3;
    spi_frame(21, 1);
    check("abort_no_write", wr_cnt - w0, 0);
    check("abort_busy", busy, 0);
    check("abort_miso", miso, 0);
    fb[0] = 8'h02; fb[1] = 8'h20; fb[2] = 8'h00;
    spi_frame(24, 1);
    check("abort_mem_kept", fr[2], 8'h3C);

    // reset during a burst write after one committed byte
    w0 = wr_cnt;
    fb[0] = 8'h03; fb[1] = 8'h40; fb[2] = 8'h77; fb[3] = 8'h88;
    spi_frame(27, 0);
    repeat (6) @(negedge clk);
    check("rstmid_committed", wr_cnt - w0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_miso", miso, 0);
    check("rstmid_wr_addr", wr_addr, 0);
    check("rstmid_wr_strobe", wr_strobe, 0);
    check("rstmid_cmd_err", cmd_err, 0);
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    fb[0] = 8'h02; fb[1] = 8'h40; fb[2] = 8'h00;
    spi_frame(24, 1);
    check("rstmid_mem_40", fr[2], 0);
    fb[1] = 8'h10;
    spi_frame(24, 1);
    check("rstmid_mem_10", fr[2], 0);

    // randomized frames against a reference memory
    for (int unsigned i = 0; i < 256; i++) mem_m[i] = '0;
    scnt = 0;
    for (int unsigned f = 0; f < 150; f++) begin
      case ($urandom_range(0, 7))
        0: cmd = 8'h01;
        1: cmd = 8'h02;
        2: cmd = 8'h03;
        3: cmd = 8'h04;
        4: cmd = 8'h05;
        5: cmd = 8'h07;
        6: cmd = 8'h81;
        default: cmd = 8'($urandom_range(0, 255));
      endcase
      a = 8'($urandom_range(0, 255));
      nbytes = 2 + $urandom_range(1, 3);
      fb[0] = cmd; fb[1] = a;
      for (int unsigned k = 2; k < nbytes; k++) fb[k] = 8'($urandom_range(0, 255));
      nbits = nbytes * 8;
      if ($urandom_range(0, 3) == 0) nbits = $urandom_range(1, nbits - 1);
      w0 = wr_cnt; e0 = ce_cnt;
      spi_frame(nbits, 1);
      full = nbits / 8;
      exp_wr = 0; exp_err = 0;
      exp_addr.delete();
      if (full >= 1) begin
        if (!ref_valid(cmd)) begin
          exp_err = 1;
          if (scnt != 15) scnt++;
          for (int unsigned k = 0; k < full; k++) check("rnd_err_miso", fr[k], 0);
        end else if (cmd == 8'h01 || cmd == 8'h03) begin
          for (int unsigned k = 2; k < full; k++) begin
            if (cmd == 8'h01 && k > 2) break;
            idx = a + 8'(k - 2);
            mem_m[idx] = fb[k];
            exp_addr.push_back(idx);
            exp_wr++;
          end
        end else if (cmd == 8'h02 || cmd == 8'h04) begin
          for (int unsigned k = 2; k < full; k++) begin
            idx = a + 8'(k - 2);
            expb = (cmd == 8'h02 && k > 2) ? 8'h00 : mem_m[idx];
            check("rnd_read", fr[k], expb);
          end
        end
`ifdef SPI_MEM_STATUS_EN
        else begin
          for (int unsigned k = 1; k < full; k++) begin
            expb = (k == 1) ? 8'(scnt) : 8'h00;
            check("rnd_status", fr[k], expb);
          end
          if (full >= 2) scnt = 0;
        end
`endif
      end
      check("rnd_wr_count", wr_cnt - w0, exp_wr);
      check("rnd_cmd_err", ce_cnt - e0, exp_err);
      check("rnd_busy", busy, 0);
      if (wr_cnt - w0 == exp_wr) begin
        for (int unsigned j = 0; j < exp_wr; j++) check("rnd_wr_addr", wr_log[w0 + j], exp_addr[j]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
